// File: rtl/mips_muldiv_unit.sv
// Multiply/divide unit owning the MIPS HI/LO registers.
// Multiply-class ops take one cycle. Divides run a restoring divider,
// one quotient bit per clock.
module mips_muldiv_unit #(
   parameter int unsigned DIV_STEPS = 32
) (
   input  logic        muu_clock,
   input  logic        muu_reset_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 6;

   typedef enum logic [2:0] {
      S_IDLE, S_MUL, S_DIV_RUN, S_DIV_FIX, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic [W-1:0]       rem_q, rem_d, quo_q, quo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [W-1:0]       hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

   logic               mul_signed, div_signed;
   logic [2*W-1:0]     ext_a, ext_b, prod, acc;
   logic [W:0]         rem_sh;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      cnt_d      = cnt_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dbz_d      = 1'b0;

      // Sign/zero extension to 64 bits makes one unsigned multiply serve both
      mul_signed = ~op_q[0];
      ext_a      = {{W{mul_signed & a_q[W-1]}}, a_q};
      ext_b      = {{W{mul_signed & b_q[W-1]}}, b_q};
      prod       = ext_a * ext_b;
      case (op_q[2:1])
         2'b01:   acc = {hi_q, lo_q} + prod;
         2'b10:   acc = {hi_q, lo_q} - prod;
         default: acc = prod;
      endcase

      rem_sh     = {rem_q, quo_q[W-1]};
      div_signed = (op == 4'd6);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                     state_d = S_MUL;
                     op_d    = op[2:0];
                     a_d     = operand_a;
                     b_d     = operand_b;
                  end
                  4'd6, 4'd7: begin
                     if (operand_b == '0) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                     end else begin
                        state_d   = S_DIV_RUN;
                        quo_d     = (div_signed && operand_a[W-1]) ? W'(-operand_a) : operand_a;
                        b_d       = (div_signed && operand_b[W-1]) ? W'(-operand_b) : operand_b;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = div_signed & (operand_a[W-1] ^ operand_b[W-1]);
                        neg_rem_d = div_signed & operand_a[W-1];
                     end
                  end
                  4'd8: begin
                     hi_d    = operand_a;
                     state_d = S_DONE;
                  end
                  4'd9: begin
                     lo_d    = operand_a;
                     state_d = S_DONE;
                  end
                  default: state_d = S_DONE;
               endcase
            end
         end
         S_MUL: begin
            hi_d    = acc[2*W-1:W];
            lo_d    = acc[W-1:0];
            state_d = S_DONE;
         end
         S_DIV_RUN: begin
            // Dividend shifts out of quo_q MSB-first while quotient bits enter at the LSB
            if (rem_sh >= {1'b0, b_q}) begin
               rem_d = W'(rem_sh - {1'b0, b_q});
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[W-1:0];
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = S_DIV_FIX;
         end
         S_DIV_FIX: begin
            lo_d    = neg_quo_q ? W'(-quo_q) : quo_q;
            hi_d    = neg_rem_q ? W'(-rem_q) : rem_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_MUL) || (state_d == S_DIV_RUN) || (state_d == S_DIV_FIX);
      done_d = (state_d == S_DONE);
   end

   // State and register update
   always_ff @(posedge muu_clock or negedge muu_reset_n) begin
      if (!muu_reset_n) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus pushes expected HI/LO,
// div_by_zero and done latency; a monitor pops on every done pulse.
module tb_mips_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          issue;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   busy_cycles = 0;
   int   issue_cyc = 0;

   mips_muldiv_unit dut (
      .muu_clock   (clk),
      .muu_reset_n (rst_n),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   // Cycle count used for latency checks
   always @(posedge clk) cyc++;

   // Busy occupancy per operation
   always @(negedge clk) if (busy) busy_cycles++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("hi", hi, mon_e.hi);
            chk("lo", lo, mon_e.lo);
            chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
            chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
         end
      end
   end

   // Present one request for exactly one accepting edge
   task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      @(posedge clk);
      #1;
      issue_cyc   = cyc;
      busy_cycles = 0;
      start       = 1'b0;
      operand_a   = 32'h5a5a5a5a;
      operand_b   = 32'ha5a5a5a5;
   endtask

   task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edbz, input int elat);
      exp_t e;
      drive(o, a, b);
      e.hi = eh; e.lo = el; e.dbz = edbz; e.issue = issue_cyc; e.lat = elat;
      sb_q.push_back(e);
   endtask

   // Bounded wait for the scoreboard to drain, then check busy occupancy
   task automatic wait_done(input string name, input int exp_busy);
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 100) begin
         @(negedge clk);
         #1;
         i++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, i);
         sb_q.delete();
      end else begin
         chk({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
      end
   endtask

   task automatic run(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input logic edbz, input int elat,
                      input int exp_busy);
      send(o, a, b, eh, el, edbz, elat);
      wait_done(name, exp_busy);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      rst_n = 1'b1;

      // Multiply class
      run("mult",  4'd0, 32'hfffffffe, 32'h0000000e, 32'hffffffff, 32'hffffffe4, 1'b0, 1, 1);
      run("madd",  4'd2, 32'hffffffe4, 32'hffffffff, 32'h00000000, 32'h00000000, 1'b0, 1, 1);
      run("msubu", 4'd5, 32'hfffffffe, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1, 1);

      // Divides, including divide by zero and the overflow case
      run("div0",  4'd6, 32'h00000000, 32'hfffffffe, 32'h00000000, 32'h00000000, 1'b0, 33, 33);
      run("dbz",   4'd6, 32'hfffffffe, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 0, 0);
      run("divn",  4'd6, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 1'b0, 33, 33);
      run("divu",  4'd7, 32'hffffffff, 32'h00000010, 32'h0000000f, 32'h0fffffff, 1'b0, 33, 33);
      run("divov", 4'd6, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0, 33, 33);

      // Moves and no-op
      run("mthi",  4'd8, 32'h12345678, 32'h0, 32'h12345678, 32'h80000000, 1'b0, 0, 0);
      run("mtlo",  4'd9, 32'h9abcdef0, 32'h0, 32'h12345678, 32'h9abcdef0, 1'b0, 0, 0);
      run("nop",   4'd12, 32'hffffffff, 32'hffffffff, 32'h12345678, 32'h9abcdef0, 1'b0, 0, 0);

      // Start during an in-flight divide must be ignored
      send(4'd6, 32'd100, 32'd7, 32'h00000002, 32'h0000000e, 1'b0, 33);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 4'd8; operand_a = 32'hdeadbeef;
      @(negedge clk);
      start = 1'b0;
      wait_done("div_ign", 33);

      // Accumulating multiplies on top of a known HI/LO
      run("maddu", 4'd3, 32'hffffffff, 32'h00000002, 32'h00000004, 32'h0000000c, 1'b0, 1, 1);
      run("msub",  4'd4, 32'h00000003, 32'h00000005, 32'h00000003, 32'hfffffffd, 1'b0, 1, 1);
      run("multu", 4'd1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0, 1, 1);

      // Reset partway through a divide aborts it without a done pulse
      drive(4'd6, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run("mult_after_rst", 4'd0, 32'h00000007, 32'hfffffffd, 32'hffffffff, 32'hffffffeb, 1'b0, 1, 1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
